delay_calibrator32: RTL and testbench

Measures the cycle delay between a strobe entering a processing path and the same strobe leaving it. Computes the 5-bit latency setting that makes the path delay plus a delayfifo32 delay equal a requested total. It drives the latency input of delayfifo32 instances so that luma and chroma paths align in the composite encoder. It repeatedly re-measures, asserts locked only after consistent results, and flags faults.

---
 rtl/delay_cal_pkg.sv | 34 +++
 rtl/strobe_interval_counter.sv | 54 +++++
 rtl/delay_calibrator32.sv | 156 +++++++++++++++
 tb/tb_delay_calibrator32.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_cal_pkg.sv
// Shared types and constants for the strobe delay calibrator.
// Holds the FSM state and error encodings plus interval-counter limits.
// No logic lives here apart from the alignment arithmetic helper.
package delay_cal_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARMED    = 3'd1,
      COUNTING = 3'd2,
      CHECK    = 3'd3,
      FAULT    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_TIMEOUT = 2'd1,
      ERR_SHORT   = 2'd2,
      ERR_LONG    = 2'd3
   } err_t;

   localparam int COUNT_MAX   = 63;
   localparam int LATENCY_MAX = 31;
   localparam int CNT_W       = 6;
   localparam int LAT_W       = 5;

   // Latency the FIFO still has to add: target - path delay - FIFO overhead,
   // as an 8-bit two's-complement value (range -65..125 fits).
   function automatic logic [7:0] calc_need(input logic [6:0] target,
                                            input logic [CNT_W-1:0] d,
                                            input logic [7:0] overhead);
      calc_need = {1'b0, target} - {2'b00, d} - overhead;
   endfunction

endpackage

// File: rtl/strobe_interval_counter.sv
// Interval counter between the reference and delayed strobes.
// elapsed = cycles since the clearing ref_strobe; timeout_o fires when that hits COUNT_MAX.
// d_o holds the last captured interval until the next capture.
module strobe_interval_counter
   import delay_cal_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic             cap_i,
   input  logic             cap_zero_i,
   output logic [CNT_W-1:0] d_o,
   output logic             timeout_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] d_q, d_d;
   logic [CNT_W-1:0] elapsed;

   // cnt_q is cleared on the ref_strobe edge, so in COUNTING the interval
   // being tested this cycle is one more than the stored count.
   assign elapsed   = cnt_q + 6'd1;
   assign timeout_o = inc_i && (elapsed == CNT_W'(COUNT_MAX));
   assign d_o       = d_q;

   // Next count and captured interval.
   always_comb begin
      cnt_d = cnt_q;
      d_d   = d_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !timeout_o) begin
         cnt_d = elapsed;
      end
      if (cap_zero_i) begin
         d_d = '0;
      end else if (cap_i) begin
         d_d = elapsed;
      end
   end

   // Counter and capture registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         d_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         d_q   <= d_d;
      end
   end

endmodule

// File: rtl/delay_calibrator32.sv
// Measures path delay between ref/dly strobes and derives the delayfifo32 latency.
// locked/latency update 2 cycles after the dly_strobe of the final matching measurement.
// start restarts calibration from any state; FAULT is left only by start or rst.
module delay_calibrator32
   import delay_cal_pkg::*;
#(
   parameter int LOCK_COUNT    = 4,
   parameter int FIFO_OVERHEAD = 2
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [6:0]       target_delay,
   input  logic             ref_strobe,
   input  logic             dly_strobe,
   output logic [CNT_W-1:0] measured,
   output logic [LAT_W-1:0] latency,
   output logic             locked,
   output logic             busy,
   output logic [1:0]       err_code
);

   state_t           state_q, state_d;
   err_t             err_q, err_d;
   logic [CNT_W-1:0] measured_q, measured_d;
   logic [CNT_W-1:0] prev_q, prev_d;
   logic [LAT_W-1:0] latency_q, latency_d;
   logic [3:0]       lock_cnt_q, lock_cnt_d;
   logic             locked_q, locked_d;

   logic             cnt_clr, cnt_inc, cap, cap_zero, timeout;
   logic [CNT_W-1:0] d_meas;
   logic [7:0]       need;
   logic [3:0]       lock_cnt_nxt;

   strobe_interval_counter u_counter (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_i      (cnt_clr),
      .inc_i      (cnt_inc),
      .cap_i      (cap),
      .cap_zero_i (cap_zero),
      .d_o        (d_meas),
      .timeout_o  (timeout)
   );

   assign need = calc_need(target_delay, d_meas, 8'(FIFO_OVERHEAD));

   // FSM, lock tracking and latency computation.
   always_comb begin
      state_d      = state_q;
      err_d        = err_q;
      measured_d   = measured_q;
      prev_d       = prev_q;
      latency_d    = latency_q;
      lock_cnt_d   = lock_cnt_q;
      locked_d     = locked_q;
      cnt_clr      = 1'b0;
      cnt_inc      = 1'b0;
      cap          = 1'b0;
      cap_zero     = 1'b0;
      lock_cnt_nxt = lock_cnt_q;
      if (start) begin
         state_d    = ARMED;
         err_d      = ERR_NONE;
         locked_d   = 1'b0;
         lock_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: ;
            ARMED: begin
               if (ref_strobe) begin
                  cnt_clr = 1'b1;
                  if (dly_strobe) begin
                     cap_zero = 1'b1;
                     state_d  = CHECK;
                  end else begin
                     state_d  = COUNTING;
                  end
               end
            end
            COUNTING: begin
               cnt_inc = 1'b1;
               // A dly_strobe on the last legal count still wins over timeout.
               if (dly_strobe) begin
                  cap     = 1'b1;
                  state_d = CHECK;
               end else if (timeout) begin
                  err_d    = ERR_TIMEOUT;
                  locked_d = 1'b0;
                  state_d  = FAULT;
               end
            end
            CHECK: begin
               measured_d = d_meas;
               state_d    = ARMED;
               if (need[7]) begin
                  err_d    = ERR_SHORT;
                  locked_d = 1'b0;
                  state_d  = FAULT;
               end else if (need > 8'(LATENCY_MAX)) begin
                  err_d    = ERR_LONG;
                  locked_d = 1'b0;
                  state_d  = FAULT;
               end else begin
                  if (d_meas == prev_q) begin
                     lock_cnt_nxt = (lock_cnt_q >= 4'(LOCK_COUNT)) ? lock_cnt_q
                                                                   : lock_cnt_q + 4'd1;
                  end else begin
                     lock_cnt_nxt = 4'd1;
                     prev_d       = d_meas;
                     locked_d     = 1'b0;
                  end
                  lock_cnt_d = lock_cnt_nxt;
                  if (lock_cnt_nxt == 4'(LOCK_COUNT)) begin
                     locked_d  = 1'b1;
                     latency_d = need[LAT_W-1:0];
                  end
               end
            end
            FAULT: begin
               locked_d = 1'b0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         err_q      <= ERR_NONE;
         measured_q <= '0;
         prev_q     <= '0;
         latency_q  <= '0;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         measured_q <= measured_d;
         prev_q     <= prev_d;
         latency_q  <= latency_d;
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
      end
   end

   assign measured = measured_q;
   assign latency  = latency_q;
   assign locked   = locked_q;
   assign err_code = err_q;
   assign busy     = (state_q == ARMED) || (state_q == COUNTING) || (state_q == CHECK);

endmodule

// File: tb/tb_delay_calibrator32.sv
// Bench for delay_calibrator32: directed scenarios plus randomized measurements.
// Expected outputs come from a transaction-level model of the calibration rules.
// Inputs change 1 time unit after posedge; outputs are sampled at the same point.
module tb_delay_calibrator32;

   localparam int LC = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [6:0] target_delay = '0;
   logic       ref_strobe = 1'b0;
   logic       dly_strobe = 1'b0;
   logic [5:0] measured;
   logic [4:0] latency;
   logic       locked;
   logic       busy;
   logic [1:0] err_code;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [5:0] m_meas;
   logic [4:0] m_lat;
   logic       m_locked, m_busy;
   logic [1:0] m_err;
   int         m_cnt, m_prev;

   logic [14:0] act, exp_v;
   assign act = {measured, latency, locked, busy, err_code};

   delay_calibrator32 #(.LOCK_COUNT(LC), .FIFO_OVERHEAD(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .target_delay (target_delay),
      .ref_strobe   (ref_strobe),
      .dly_strobe   (dly_strobe),
      .measured     (measured),
      .latency      (latency),
      .locked       (locked),
      .busy         (busy),
      .err_code     (err_code)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_meas = '0; m_lat = '0; m_locked = 1'b0; m_busy = 1'b0; m_err = 2'd0;
      m_cnt = 0; m_prev = 0;
   endtask

   task automatic model_start();
      m_err = 2'd0; m_locked = 1'b0; m_busy = 1'b1; m_cnt = 0;
   endtask

   task automatic model_measure(input int d, input int tgt);
      int need;
      need   = tgt - d - 2;
      m_meas = 6'(d);
      if (need < 0) begin
         m_err = 2'd2; m_busy = 1'b0; m_locked = 1'b0;
      end else if (need > 31) begin
         m_err = 2'd3; m_busy = 1'b0; m_locked = 1'b0;
      end else begin
         if (d == m_prev) begin
            m_cnt = (m_cnt < LC) ? m_cnt + 1 : LC;
         end else begin
            m_cnt = 1; m_prev = d; m_locked = 1'b0;
         end
         if (m_cnt == LC) begin
            m_locked = 1'b1; m_lat = 5'(need);
         end
      end
   endtask

   task automatic model_pack();
      exp_v = {m_meas, m_lat, m_locked, m_busy, m_err};
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      model_start();
   endtask

   // Drive a ref/dly pair with interval d; returns just after the edge that
   // samples dly_strobe (the DUT is then in CHECK).
   task automatic send_strobes(input int d);
      if (d == 0) begin
         ref_strobe = 1'b1; dly_strobe = 1'b1;
         tick();
         ref_strobe = 1'b0; dly_strobe = 1'b0;
      end else begin
         ref_strobe = 1'b1;
         tick();
         ref_strobe = 1'b0;
         repeat (d - 1) tick();
         dly_strobe = 1'b1;
         tick();
         dly_strobe = 1'b0;
      end
   endtask

   // Full measurement: strobes, CHECK edge, model update.
   task automatic measure(input int d);
      send_strobes(d);
      tick();
      model_measure(d, int'(target_delay));
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; ref_strobe = 1'b1; dly_strobe = 1'b1;
      repeat (3) tick();
      checks++;
      if (act !== 15'd0) begin
         errors++; $display("FAIL reset_hold act=%h exp=%h", act, 15'd0);
      end
      rst = 1'b0; start = 1'b0; ref_strobe = 1'b0; dly_strobe = 1'b0;
      model_reset();
      tick();
      checks++;
      if (act !== 15'd0) begin
         errors++; $display("FAIL reset_release act=%h exp=%h", act, 15'd0);
      end
   endtask

   task automatic test_lock_basic();
      do_start();
      target_delay = 7'd20;
      for (int i = 0; i < 4; i++) begin
         send_strobes(5);
         model_pack();
         checks++;
         if (act !== exp_v) begin
            errors++; $display("FAIL lock_basic_pre%0d act=%h exp=%h", i, act, exp_v);
         end
         tick();
         model_measure(5, 20);
         model_pack();
         checks++;
         if (act !== exp_v) begin
            errors++; $display("FAIL lock_basic_post%0d act=%h exp=%h", i, act, exp_v);
         end
         repeat (8) tick();
      end
      checks++;
      if ({measured, latency, locked, busy} !== {6'd5, 5'd13, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL lock_basic_final act=%0d/%0d/%b/%b exp=5/13/1/1",
                  measured, latency, locked, busy);
      end
   endtask

   task automatic test_relock();
      int seq[6] = '{5, 5, 6, 6, 6, 6};
      do_start();
      target_delay = 7'd20;
      for (int i = 0; i < 6; i++) begin
         measure(seq[i]);
         model_pack();
         checks++;
         if (act !== exp_v) begin
            errors++; $display("FAIL relock_%0d act=%h exp=%h", i, act, exp_v);
         end
         repeat (3) tick();
      end
      checks++;
      if ({latency, locked} !== {5'd12, 1'b1}) begin
         errors++; $display("FAIL relock_final act=%0d/%b exp=12/1", latency, locked);
      end
   endtask

   task automatic test_zero_delay();
      do_start();
      target_delay = 7'd2;
      for (int i = 0; i < 4; i++) begin
         measure(0);
         model_pack();
         checks++;
         if (act !== exp_v) begin
            errors++; $display("FAIL zero_%0d act=%h exp=%h", i, act, exp_v);
         end
      end
      checks++;
      if ({measured, latency, locked} !== {6'd0, 5'd0, 1'b1}) begin
         errors++; $display("FAIL zero_lock act=%0d/%0d/%b exp=0/0/1", measured, latency, locked);
      end
      target_delay = 7'd1;
      measure(0);
      model_pack();
      checks++;
      if ({err_code, locked, busy} !== {2'd2, 1'b0, 1'b0} || act !== exp_v) begin
         errors++; $display("FAIL zero_short act=%h exp=%h", act, exp_v);
      end
      // Strobes in FAULT must not change anything.
      send_strobes(3);
      tick();
      checks++;
      if (act !== exp_v) begin
         errors++; $display("FAIL fault_hold act=%h exp=%h", act, exp_v);
      end
   endtask

   task automatic test_timeout();
      do_start();
      model_pack();
      checks++;
      if (act !== exp_v || err_code !== 2'd0 || busy !== 1'b1) begin
         errors++; $display("FAIL fault_restart act=%h exp=%h", act, exp_v);
      end
      ref_strobe = 1'b1;
      tick();
      ref_strobe = 1'b0;
      repeat (62) tick();
      checks++;
      if ({busy, err_code} !== {1'b1, 2'd0}) begin
         errors++; $display("FAIL timeout_early act=%b/%0d exp=1/0", busy, err_code);
      end
      tick();
      m_err = 2'd1; m_busy = 1'b0; m_locked = 1'b0;
      model_pack();
      checks++;
      if ({busy, err_code, locked} !== {1'b0, 2'd1, 1'b0} || act !== exp_v) begin
         errors++; $display("FAIL timeout act=%h exp=%h", act, exp_v);
      end
      repeat (6) tick();
      do_start();
      checks++;
      if ({busy, err_code} !== {1'b1, 2'd0}) begin
         errors++; $display("FAIL timeout_clear act=%b/%0d exp=1/0", busy, err_code);
      end
   endtask

   task automatic test_bounds();
      target_delay = 7'd40;
      measure(1);
      model_pack();
      checks++;
      if (err_code !== 2'd3 || act !== exp_v) begin
         errors++; $display("FAIL too_long act=%h exp=%h", act, exp_v);
      end
      do_start();
      for (int i = 0; i < 4; i++) measure(7);
      model_pack();
      checks++;
      if ({latency, locked, err_code} !== {5'd31, 1'b1, 2'd0} || act !== exp_v) begin
         errors++; $display("FAIL lat_max act=%h exp=%h", act, exp_v);
      end
      // Longest accepted interval: dly on the 63rd cycle.
      do_start();
      target_delay = 7'd96;
      measure(63);
      model_pack();
      checks++;
      if (measured !== 6'd63 || err_code !== 2'd0 || act !== exp_v) begin
         errors++; $display("FAIL d63 act=%h exp=%h", act, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      do_start();
      target_delay = 7'd20;
      for (int i = 0; i < 4; i++) measure(5);
      checks++;
      if ({latency, locked} !== {5'd13, 1'b1}) begin
         errors++; $display("FAIL pre_reset_lock act=%0d/%b exp=13/1", latency, locked);
      end
      ref_strobe = 1'b1;
      tick();
      ref_strobe = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      checks++;
      if (act !== 15'd0) begin
         errors++; $display("FAIL reset_mid act=%h exp=%h", act, 15'd0);
      end
      send_strobes(4);
      repeat (3) tick();
      checks++;
      if (act !== 15'd0) begin
         errors++; $display("FAIL idle_ignore act=%h exp=%h", act, 15'd0);
      end
      do_start();
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL idle_start act=%b exp=1", busy);
      end
   endtask

   task automatic test_random();
      int d;
      d = 5;
      target_delay = 7'd30;
      for (int i = 0; i < 40; i++) begin
         if (m_err != 2'd0) do_start();
         if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 40);
         if ($urandom_range(0, 7) == 0) target_delay = 7'($urandom_range(0, 90));
         measure(d);
         model_pack();
         checks++;
         if (act !== exp_v) begin
            errors++; $display("FAIL random_%0d d=%0d act=%h exp=%h", i, d, act, exp_v);
         end
         repeat ($urandom_range(0, 4)) tick();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lock_basic();
      test_relock();
      test_zero_delay();
      test_timeout();
      test_bounds();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
